// File: rtl/modu_ampl_pkg.sv
// Shared definitions for the AM demodulator slice.
//   DATA_W      : width of ADC samples and recovered samples
//   BIAS        : default offset-binary midscale
//   CLIP_W      : width of the saturating clip counter
//   avg_state_t : block-averager FSM encoding
package modu_ampl_pkg;

  localparam int DATA_W = 12;
  localparam int BIAS   = 2047;
  localparam int CLIP_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } avg_state_t;

endpackage

// File: rtl/modu_ampl_demod_if.sv
// Sample-stream interface of the AM demodulator.
//   en, adc_valid, adc_data : sample input side (driven by master)
//   modu_data, modu_valid   : recovered sample stream
//   avg_data, avg_valid     : block average stream
//   clip_cnt                : saturating clipped-sample count
interface modu_ampl_demod_if;
  import modu_ampl_pkg::*;

  logic              en;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] modu_data;
  logic              modu_valid;
  logic [DATA_W-1:0] avg_data;
  logic              avg_valid;
  logic [CLIP_W-1:0] clip_cnt;

  modport master (
    output en, adc_valid, adc_data,
    input  modu_data, modu_valid, avg_data, avg_valid, clip_cnt
  );

  modport slave (
    input  en, adc_valid, adc_data,
    output modu_data, modu_valid, avg_data, avg_valid, clip_cnt
  );

endinterface

// File: rtl/modu_avg_acc.sv
// Block averager: sums 2^AVG_LOG2 recovered samples and emits their
// truncated mean.
//   clk, rst     : clock, async active-high reset
//   en           : block enable; low discards any partial block
//   sample_valid : qualifies sample
//   sample       : recovered sample to accumulate
//   avg_data     : mean of the last completed block (held between strobes)
//   avg_valid    : one-cycle strobe qualifying avg_data
module modu_avg_acc
  import modu_ampl_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] LAST = '1;

  avg_state_t        state, state_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [AVG_LOG2-1:0] cnt, cnt_next;
  logic [DATA_W-1:0] avg_data_next;
  logic              avg_valid_next;
  logic [ACC_W-1:0]  sample_ext;

  assign sample_ext = {{AVG_LOG2{1'b0}}, sample};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      avg_data  <= avg_data_next;
      avg_valid <= avg_valid_next;
    end
  end

  // The counter only needs to spot the last sample of a block; it wraps
  // harmlessly on that add because DUMP reloads it anyway.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    cnt_next       = cnt;
    avg_data_next  = avg_data;
    avg_valid_next = 1'b0;

    case (state)
      IDLE: begin
        acc_next = '0;
        cnt_next = '0;
        if (en) state_next = ACCUM;
      end

      ACCUM: begin
        if (!en) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (sample_valid) begin
          acc_next = acc + sample_ext;
          cnt_next = cnt + 1'b1;
          if (cnt == LAST) state_next = DUMP;
        end
      end

      DUMP: begin
        // The upper DATA_W bits of the accumulator are exactly acc >> AVG_LOG2.
        avg_data_next  = acc[AVG_LOG2 +: DATA_W];
        avg_valid_next = 1'b1;
        if (!en) begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (sample_valid) begin
          // A sample arriving during DUMP starts the next block so none is lost.
          state_next = ACCUM;
          acc_next   = sample_ext;
          cnt_next   = {{(AVG_LOG2-1){1'b0}}, 1'b1};
        end else begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/modu_ampl_demod.sv
// AM demodulator top: removes the offset-binary bias, doubles and clamps
// each sample into the unsigned 12-bit range, counts clipped samples, and
// feeds the recovered stream to the block averager.
//   clk, rst : clock, async active-high reset
//   bus      : sample-stream interface (slave side)
module modu_ampl_demod #(
  parameter int BIAS     = modu_ampl_pkg::BIAS,
  parameter int AVG_LOG2 = 4
) (
  input logic               clk,
  input logic               rst,
  modu_ampl_demod_if.slave  bus
);
  import modu_ampl_pkg::*;

  // One guard bit beyond 14 keeps the doubled difference exact for any BIAS.
  localparam int D_W = DATA_W + 3;
  localparam logic signed [D_W-1:0] BIAS_S = D_W'(BIAS);
  localparam logic signed [D_W-1:0] MAX_D  = D_W'(4095);
  localparam logic [CLIP_W-1:0]     CLIP_MAX = '1;

  logic                    accept;
  logic signed [D_W-1:0]   diff;
  logic signed [D_W-1:0]   dbl;
  logic [DATA_W-1:0]       clamped;
  logic                    clip;

  logic [DATA_W-1:0]       modu_data_q;
  logic                    modu_valid_q;
  logic [CLIP_W-1:0]       clip_cnt_q;
  logic [DATA_W-1:0]       avg_data_w;
  logic                    avg_valid_w;

  always_comb begin
    accept  = bus.en & bus.adc_valid;
    diff    = $signed({3'b000, bus.adc_data}) - BIAS_S;
    dbl     = diff <<< 1;
    clip    = 1'b0;
    clamped = dbl[DATA_W-1:0];
    if (dbl[D_W-1]) begin
      clamped = '0;
      clip    = 1'b1;
    end else if (dbl > MAX_D) begin
      clamped = '1;
      clip    = 1'b1;
    end
  end

  // modu_data holds its last value when no sample arrives; only the
  // strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modu_data_q  <= '0;
      modu_valid_q <= 1'b0;
      clip_cnt_q   <= '0;
    end else begin
      modu_valid_q <= accept;
      if (accept) modu_data_q <= clamped;
      if (accept && clip && (clip_cnt_q != CLIP_MAX)) clip_cnt_q <= clip_cnt_q + 1'b1;
    end
  end

  modu_avg_acc #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .rst          (rst),
    .en           (bus.en),
    .sample_valid (modu_valid_q),
    .sample       (modu_data_q),
    .avg_data     (avg_data_w),
    .avg_valid    (avg_valid_w)
  );

  assign bus.modu_data  = modu_data_q;
  assign bus.modu_valid = modu_valid_q;
  assign bus.clip_cnt   = clip_cnt_q;
  assign bus.avg_data   = avg_data_w;
  assign bus.avg_valid  = avg_valid_w;

endmodule

// File: tb/tb_modu_ampl_demod.sv
// Self-checking bench for modu_ampl_demod: table of single-sample decode
// vectors plus hand-written streaming, enable-drop, async-reset and
// clip-saturation sequences.
module tb_modu_ampl_demod;

  logic clk = 1'b0;
  logic rst = 1'b0;

  modu_ampl_demod_if bus();

  modu_ampl_demod #(
    .BIAS     (2047),
    .AVG_LOG2 (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int avg_q[$];
  int avg_cyc_q[$];

  typedef struct {
    logic [11:0] adc;
    logic [11:0] exp_modu;
    bit          exp_clip;
  } vec_t;

  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every average strobe with the edge count it appeared after.
  always @(negedge clk) begin
    if (bus.avg_valid) begin
      avg_q.push_back(int'(bus.avg_data));
      avg_cyc_q.push_back(cyc);
    end
  end

  function automatic int decodeRef(input int a);
    int d;
    d = (a - 2047) * 2;
    if (d < 0) return 0;
    if (d > 4095) return 4095;
    return d;
  endfunction

  function automatic int avgAt(input int k);
    if (avg_q.size() > k) return avg_q[k];
    return -1;
  endfunction

  function automatic int avgCycAt(input int k);
    if (avg_cyc_q.size() > k) return avg_cyc_q[k];
    return -1;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] adc);
    bus.en        = 1'b1;
    bus.adc_valid = 1'b1;
    bus.adc_data  = adc;
    stepCycle();
    bus.adc_valid = 1'b0;
  endtask

  task automatic streamSamples(input int first, input int step, input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      bus.en        = 1'b1;
      bus.adc_valid = 1'b1;
      bus.adc_data  = 12'(first + i * step);
      stepCycle();
      if (chk) begin
        checkOutput("stream_modu_valid", int'(bus.modu_valid), 1);
        checkOutput("stream_modu_data", int'(bus.modu_data), decodeRef(first + i * step));
      end
    end
    bus.adc_valid = 1'b0;
  endtask

  task automatic clearAvg();
    avg_q.delete();
    avg_cyc_q.delete();
  endtask

  task automatic resetDut();
    bus.en        = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    rst = 1'b1;
    repeat (2) stepCycle();
    rst = 1'b0;
    stepCycle();
    clearAvg();
  endtask

  initial begin
    int last_edge;
    int exp_clip_total;

    vecs[0] = '{12'd2047, 12'd0,    1'b0};
    vecs[1] = '{12'd2046, 12'd0,    1'b1};
    vecs[2] = '{12'd4095, 12'd4095, 1'b1};
    vecs[3] = '{12'd0,    12'd0,    1'b1};
    vecs[4] = '{12'd3071, 12'd2048, 1'b0};
    vecs[5] = '{12'd2048, 12'd2,    1'b0};
    vecs[6] = '{12'd4094, 12'd4094, 1'b0};
    vecs[7] = '{12'd2559, 12'd1024, 1'b0};

    bus.en        = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_modu_data",  int'(bus.modu_data), 0);
    checkOutput("reset_modu_valid", int'(bus.modu_valid), 0);
    checkOutput("reset_avg_data",   int'(bus.avg_data), 0);
    checkOutput("reset_avg_valid",  int'(bus.avg_valid), 0);
    checkOutput("reset_clip_cnt",   int'(bus.clip_cnt), 0);
    repeat (2) stepCycle();
    rst = 1'b0;

    // With en low a valid sample must be ignored.
    bus.adc_valid = 1'b1;
    bus.adc_data  = 12'd3071;
    stepCycle();
    checkOutput("en_low_no_accept", int'(bus.modu_valid), 0);
    bus.adc_valid = 1'b0;
    stepCycle();

    $display("[TB] constant 3071 block");
    clearAvg();
    streamSamples(3071, 0, 16, 1'b1);
    last_edge = cyc;
    repeat (4) stepCycle();
    checkOutput("const_avg_count", avg_q.size(), 1);
    checkOutput("const_avg_data", avgAt(0), 2048);
    // Strobe is visible after the second edge following the last acceptance edge.
    checkOutput("const_avg_latency", avgCycAt(0) - last_edge, 2);
    checkOutput("const_clip_cnt", int'(bus.clip_cnt), 0);

    $display("[TB] single-sample decode table");
    exp_clip_total = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].adc);
      checkOutput("vec_modu_valid", int'(bus.modu_valid), 1);
      checkOutput("vec_modu_data", int'(bus.modu_data), int'(vecs[i].exp_modu));
      exp_clip_total += int'(vecs[i].exp_clip);
      checkOutput("vec_clip_cnt", int'(bus.clip_cnt), exp_clip_total);
      stepCycle();
      checkOutput("vec_modu_valid_gap", int'(bus.modu_valid), 0);
    end
    checkOutput("table_clip_total", int'(bus.clip_cnt), 3);
    bus.en = 1'b0;
    repeat (2) stepCycle();

    $display("[TB] back-to-back ramp");
    clearAvg();
    streamSamples(2047, 1, 32, 1'b1);
    repeat (4) stepCycle();
    checkOutput("ramp_avg_count", avg_q.size(), 2);
    checkOutput("ramp_avg0", avgAt(0), 15);
    checkOutput("ramp_avg1", avgAt(1), 47);
    checkOutput("ramp_avg_spacing", avgCycAt(1) - avgCycAt(0), 16);

    $display("[TB] enable drop mid-block");
    clearAvg();
    streamSamples(3071, 0, 10, 1'b0);
    bus.en = 1'b0;
    checkOutput("drop_modu_valid_kept", int'(bus.modu_valid), 1);
    checkOutput("drop_modu_data_kept", int'(bus.modu_data), 2048);
    repeat (2) stepCycle();
    checkOutput("drop_modu_valid_low", int'(bus.modu_valid), 0);
    checkOutput("drop_avg_held", int'(bus.avg_data), 47);
    streamSamples(2559, 0, 16, 1'b0);
    repeat (4) stepCycle();
    checkOutput("drop_avg_count", avg_q.size(), 1);
    checkOutput("drop_avg_data", avgAt(0), 1024);
    checkOutput("drop_clip_cnt", int'(bus.clip_cnt), 3);

    $display("[TB] asynchronous reset mid-block");
    streamSamples(3071, 0, 8, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_modu_data",  int'(bus.modu_data), 0);
    checkOutput("async_modu_valid", int'(bus.modu_valid), 0);
    checkOutput("async_avg_data",   int'(bus.avg_data), 0);
    checkOutput("async_avg_valid",  int'(bus.avg_valid), 0);
    checkOutput("async_clip_cnt",   int'(bus.clip_cnt), 0);
    stepCycle();
    rst = 1'b0;
    clearAvg();
    streamSamples(2559, 0, 16, 1'b0);
    repeat (4) stepCycle();
    checkOutput("post_reset_avg_count", avg_q.size(), 1);
    checkOutput("post_reset_avg_data", avgAt(0), 1024);

    $display("[TB] clip counter saturation");
    resetDut();
    streamSamples(0, 0, 65534, 1'b0);
    checkOutput("clip_below_max", int'(bus.clip_cnt), 65534);
    streamSamples(0, 0, 70000 - 65534, 1'b0);
    stepCycle();
    checkOutput("clip_saturated", int'(bus.clip_cnt), 65535);
    checkOutput("clip_modu_data", int'(bus.modu_data), 0);
    clearAvg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
